// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//   Shares one bitwise logic unit among four requesters. A round-robin
//   arbiter picks one requester while IDLE. Its opcode and operands are
//   captured, then evaluated in EXEC. The result is held in RESP until the
//   downstream consumer takes it.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   req_valid  : [3:0] per-requester request strobe
//   req_op     : [11:0] 3-bit opcode per requester (requester i at [3i+2:3i])
//   req_a      : [4*WIDTH-1:0] operand A per requester (slice i)
//   req_b      : [4*WIDTH-1:0] operand B per requester (slice i)
//   req_ready  : [3:0] one-hot accept, combinational, only in IDLE
//   rsp_valid  : result available (RESP state)
//   rsp_ready  : downstream accepts the result
//   rsp_id     : [1:0] requester that owns the result
//   rsp_y      : [WIDTH-1:0] bitwise result
//   rsp_err    : illegal opcode flag, qualified by rsp_valid
//   busy       : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_last_grant;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_idx;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_y;
  logic [1:0]         r_rsp_id;
  logic               r_rsp_err;
  logic               r_busy;

  // Per-requester unpacked views of the flat request buses
  logic [2:0]         w_op [4];
  logic [WIDTH-1:0]   w_a  [4];
  logic [WIDTH-1:0]   w_b  [4];

  // w_cand[k] is the requester examined at round-robin distance k+1 from
  // the last grant; w_hit[k] says whether that candidate is requesting.
  logic [1:0]         w_cand [4];
  logic [3:0]         w_hit;

  logic               w_grant_any;
  logic [1:0]         w_grant_idx;

  logic [WIDTH-1:0]   w_alu_y;
  logic               w_alu_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign w_op[gi]   = req_op[3*gi +: 3];
    assign w_a[gi]    = req_a[WIDTH*gi +: WIDTH];
    assign w_b[gi]    = req_b[WIDTH*gi +: WIDTH];
    assign w_cand[gi] = r_last_grant + 2'(gi + 1);
    assign w_hit[gi]  = req_valid[w_cand[gi]];
  end

  // Nearest requesting candidate wins: scan from farthest to nearest so the
  // closest hit overwrites any farther one.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = r_last_grant;
    for (int k = 3; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand[k];
      end
    end
  end

  // Accept is only offered in IDLE and is forced low during reset.
  assign req_ready = (!rst && (r_state == ST_IDLE) && w_grant_any)
                   ? (4'b0001 << w_grant_idx) : 4'b0000;

  // Shared bitwise unit, operating only on the captured operands
  always_comb begin
    w_alu_y   = '0;
    w_alu_err = 1'b0;
    case (r_op)
      3'b000:  w_alu_y = r_a & r_b;
      3'b001:  w_alu_y = r_a | r_b;
      3'b010:  w_alu_y = ~r_a;
      3'b011:  w_alu_y = ~(r_a & r_b);
      3'b100:  w_alu_y = ~(r_a | r_b);
      3'b101:  w_alu_y = r_a ^ r_b;
      3'b110:  w_alu_y = ~(r_a ^ r_b);
      default: w_alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 2'd3;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_idx        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_y      <= '0;
      r_rsp_id     <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_op         <= w_op[w_grant_idx];
            r_a          <= w_a[w_grant_idx];
            r_b          <= w_b[w_grant_idx];
            r_idx        <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_y     <= w_alu_y;
          r_rsp_err   <= w_alu_err;
          r_rsp_id    <= r_idx;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // Response fields are left untouched so they stay readable after
          // the handshake; only rsp_valid drops.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_op_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model runs on the falling edge. It predicts the grant,
//   response timing, payload and busy/hold behaviour.
// ---------------------------------------------------------------------------
module tb_logic_op_arbiter;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [11:0]    req_op;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_y;
  logic           rsp_err;
  logic           busy;

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {err, y} straight from the opcode table
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] y;
    logic         e;
    y = '0;
    e = 1'b0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = ~a;
      3'd3: y = ~(a & b);
      3'd4: y = ~(a | b);
      3'd5: y = a ^ b;
      3'd6: y = a ~^ b;
      default: e = 1'b1;
    endcase
    return {e, y};
  endfunction

  // Round-robin choice: first requester found starting after the last grant
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- reference model (falling edge) ----------------
  int           cyc = 0;
  int           m_last = 3;
  bit           m_busy = 1'b0;
  int           m_acc = 0;
  int           m_id = 0;
  logic [W-1:0] m_y = '0;
  logic         m_err = 1'b0;
  logic [W-1:0] h_y = '0;
  logic [1:0]   h_id = '0;
  logic         h_err = 1'b0;
  logic [3:0]   seen_ready = '0;
  int           grant_log[$];
  int           grant_cyc[$];

  always @(negedge clk) begin
    int         w;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [W:0] r;
    cyc++;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_rsp_y",     32'(rsp_y),     32'd0);
      check("rst_rsp_id",    32'(rsp_id),    32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      m_last = 3; m_busy = 1'b0;
      h_y = '0; h_id = '0; h_err = 1'b0;
      seen_ready = '0;
    end else begin
      w = -1;
      exp_ready = 4'b0000;
      if (!m_busy) begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) exp_ready = 4'(1 << w);
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_busy));
      exp_valid = m_busy && (cyc >= m_acc + 2);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (rsp_valid && exp_valid) begin
        check("rsp_y",   32'(rsp_y),   32'(m_y));
        check("rsp_id",  32'(rsp_id),  32'(m_id));
        check("rsp_err", 32'(rsp_err), 32'(m_err));
        h_y = m_y; h_id = 2'(m_id); h_err = m_err;
      end else if (!rsp_valid) begin
        check("hold_y",   32'(rsp_y),   32'(h_y));
        check("hold_id",  32'(rsp_id),  32'(h_id));
        check("hold_err", 32'(rsp_err), 32'(h_err));
      end
      if (exp_valid && rsp_ready) m_busy = 1'b0;
      if (w >= 0) begin
        r = ref_op(req_op[w*3 +: 3], req_a[w*W +: W], req_b[w*W +: W]);
        m_y = r[W-1:0]; m_err = r[W];
        m_id = w; m_last = w; m_acc = cyc; m_busy = 1'b1;
        grant_log.push_back(w);
        grant_cyc.push_back(cyc);
      end
      seen_ready = req_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[i*3 +: 3] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next grant logged by the model; returns its id.
  task automatic wait_grant(output int id);
    int n;
    bit got;
    n   = grant_log.size();
    got = 1'b0;
    id  = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (grant_log.size() > n) begin
        got = 1'b1;
        id  = grant_log[n];
        break;
      end
    end
    check("grant_timeout", 32'(got), 32'd1);
  endtask

  // One request on requester i from IDLE; response checked against
  // spec-given constants two cycles after the accept.
  task automatic do_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ey, input logic ee);
    int id;
    set_req(i, op, a, b);
    req_valid = 4'(1 << i);
    rsp_ready = 1'b1;
    #1;
    check("ready_same_cycle", 32'(req_ready), 32'(1 << i));
    wait_grant(id);
    check("grant_id", 32'(id), 32'(i));
    req_valid = 4'b0000;
    tick();
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    check("dir_rsp_y",     32'(rsp_y),     32'(ey));
    check("dir_rsp_id",    32'(rsp_id),    32'(i));
    check("dir_rsp_err",   32'(rsp_err),   32'(ee));
    tick();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int id;
    int base;

    // Reset with random inputs
    rst       = 1'b1;
    req_valid = 4'($urandom);
    req_op    = 12'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    rsp_ready = 1'($urandom);
    repeat (3) tick();
    rst       = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();

    // Single request and opcode spot checks
    do_req(0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0);
    do_req(2, 3'b010, 8'hA5, 8'hFF, 8'h5A, 1'b0);
    do_req(2, 3'b110, 8'hA5, 8'h0F, 8'h55, 1'b0);
    do_req(2, 3'b111, 8'h12, 8'h34, 8'h00, 1'b1);

    // Fairness with all four requesting continuously
    reset_pulse();
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'h11 * (i + 1)), 8'h5C);
    rsp_ready = 1'b1;
    base      = grant_log.size();
    req_valid = 4'b1111;
    repeat (19) tick();
    check("fair_count", 32'(grant_log.size() >= base + 6), 32'd1);
    if (grant_log.size() >= base + 6) begin
      for (int k = 0; k < 6; k++)
        check("fair_order", 32'(grant_log[base + k]), 32'(k % 4));
      for (int k = 1; k < 6; k++)
        check("fair_spacing", 32'(grant_cyc[base + k] - grant_cyc[base + k - 1]), 32'd3);
    end
    req_valid = 4'b0000;
    repeat (4) tick();

    // Backpressure: response held while rsp_ready is low
    reset_pulse();
    set_req(0, 3'b101, 8'hC3, 8'h5A);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_grant(id);
    check("bp_first", 32'(id), 32'd0);
    for (int i = 1; i < 4; i++) set_req(i, 3'b001, 8'(i), 8'h80);
    req_valid = 4'b1110;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_y",     32'(rsp_y),     32'h99);
      check("bp_id",    32'(rsp_id),    32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    wait_grant(id);
    check("bp_next", 32'(id), 32'd1);
    req_valid = 4'b0000;
    repeat (4) tick();

    // Reset while a request from requester 2 is in EXEC
    set_req(2, 3'b001, 8'h0F, 8'hF0);
    set_req(0, 3'b000, 8'hFF, 8'h0F);
    req_valid = 4'b0100;
    wait_grant(id);
    check("rm_first", 32'(id), 32'd2);
    rst       = 1'b1;
    req_valid = 4'b0101;
    tick();
    rst = 1'b0;
    wait_grant(id);
    check("rm_after0", 32'(id), 32'd0);
    req_valid = 4'b0100;
    wait_grant(id);
    check("rm_after2", 32'(id), 32'd2);
    req_valid = 4'b0000;
    repeat (4) tick();

    // Randomized traffic with protocol-respecting requesters
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (seen_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            set_req(i, 3'($urandom_range(7)), W'($urandom), W'($urandom));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(9) < 7);
      rst       = ($urandom_range(299) == 0);
      tick();
    end

    rst       = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
